// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-cycle core.
// Holds the PC, gates the fetched word to decode, halts or faults.
module fetch_unit #(
  parameter int          MEM_SIZE     = 1024,
  parameter logic [31:0] RESET_PC     = 32'h00000000,
  parameter int          CNT_W        = 32,
  parameter bit          HALT_ON_ZERO = 1'b1,
  parameter int          INST_WIDTH   = 32,
  localparam int         ADDR_W       = $clog2(MEM_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic                  i_redirect,
  input  logic [31:0]           i_target,
  input  logic [INST_WIDTH-1:0] i_inst,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [31:0]           o_pc,
  output logic [31:0]           o_pc_plus4,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic                  o_valid,
  output logic                  o_halted,
  output logic                  o_fault,
  output logic [CNT_W-1:0]      o_fetch_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [31:0] MEM_LIM = 32'(MEM_SIZE);
  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h00000013);

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_inst;
  logic             target_bad;
  logic             valid;

  assign pc_plus4   = pc_q + 32'd4;
  assign zero_inst  = HALT_ON_ZERO && (i_inst == '0);
  assign target_bad = (i_target[1:0] != 2'b00) || (i_target >= MEM_LIM);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Stall outranks the zero word, which outranks any redirect.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (state_q == RUN) begin
      if (i_stall) begin
        pc_d = pc_q;
      end else if (zero_inst) begin
        state_d = HALT;
      end else if (i_redirect) begin
        if (target_bad) state_d = FAULT;
        else            pc_d    = i_target;
      end else begin
        if (pc_plus4 >= MEM_LIM) state_d = FAULT;
        else                     pc_d    = pc_plus4;
      end
    end
  end

  always_comb begin
    valid    = (state_q == RUN) && !i_stall && !zero_inst;
    o_valid  = valid;
    o_inst   = valid ? i_inst : NOP;
    o_halted = (state_q == HALT);
    o_fault  = (state_q == FAULT);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (valid && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_addr        = pc_q[ADDR_W-1:0];
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_plus4;
  assign o_fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan sequences plus random
// stall/redirect traffic checked against a behavioural model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] inst;
  logic [9:0]  addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] inst_out;
  logic        valid;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_halt;
  logic        m_fault;

  fetch_unit dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_target      (target),
    .i_inst        (inst),
    .o_addr        (addr),
    .o_pc          (pc),
    .o_pc_plus4    (pc_plus4),
    .o_inst        (inst_out),
    .o_valid       (valid),
    .o_halted      (halted),
    .o_fault       (fault),
    .o_fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb inst = mem[addr[9:2]];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_plan_image();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h00108113;
    mem[1] = 32'h00108193;
    mem[2] = 32'h00310233;
    mem[3] = 32'hfe218ae3;
  endtask

  // One clock: drive inputs, compare outputs with the model, then
  // advance the model by the fetch rules at the rising edge.
  task automatic cycle(input logic rn, input logic st, input logic rd,
                       input logic [31:0] tg);
    logic [31:0] w;
    logic        ev;
    @(negedge clk);
    rst_n    = rn;
    stall    = st;
    redirect = rd;
    target   = tg;
    #1;
    w  = mem[m_pc[9:2]];
    ev = !m_halt && !m_fault && !st && (w != 32'h0);
    if (rn) begin
      check("pc", pc, m_pc);
      check("addr", addr, m_pc[9:0]);
      check("pc_plus4", pc_plus4, m_pc + 4);
      check("valid", valid, ev);
      check("inst", inst_out, ev ? w : 32'h00000013);
      check("halted", halted, m_halt);
      check("fault", fault, m_fault);
      check("count", fetch_count, m_cnt);
    end
    @(posedge clk);
    if (!rn) begin
      m_pc = 0; m_cnt = 0; m_halt = 0; m_fault = 0;
    end else if (!m_halt && !m_fault) begin
      if (ev && m_cnt != 32'hffffffff) m_cnt = m_cnt + 1;
      if (st) begin
      end else if (w == 32'h0) begin
        m_halt = 1;
      end else if (rd) begin
        if (tg % 4 != 0 || tg >= 1024) m_fault = 1;
        else m_pc = tg;
      end else if (m_pc + 4 >= 1024) begin
        m_fault = 1;
      end else begin
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return ($urandom_range(0, 1023) & ~32'h3) | 32'($urandom_range(1, 3));
    if (r == 1) return 32'd1024 + ($urandom & 32'h7fff_ffff);
    if (r == 2) return 32'h3f0 + 32'($urandom_range(0, 3) * 4);
    return 32'($urandom_range(0, 255) * 4);
  endfunction

  initial begin
    rst_n = 0; stall = 0; redirect = 0; target = 0;
    m_pc = 0; m_cnt = 0; m_halt = 0; m_fault = 0;
    load_plan_image();

    do_reset(2);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_halted", halted, 1'b0);
    check("rst_inst", inst_out, 32'h00108113);
    run(6);
    #1;
    check("halt_flag", halted, 1'b1);
    check("halt_pc", pc, 32'h10);
    check("halt_count", fetch_count, 32'd4);
    check("halt_valid", valid, 1'b0);

    do_reset(1);
    run(1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 32'h0);
    run(1);
    #1;
    check("stall_pc", pc, 32'h8);
    check("stall_count", fetch_count, 32'd2);

    do_reset(1);
    run(3);
    cycle(1, 0, 1, 32'h0);
    #1;
    check("redir_pc", pc, 32'h0);
    check("redir_inst", inst_out, 32'h00108113);
    check("redir_count", fetch_count, 32'd4);
    run(2);

    do_reset(1);
    run(3);
    cycle(1, 0, 1, 32'h6);
    #1;
    check("bad6_fault", fault, 1'b1);
    check("bad6_pc", pc, 32'hc);
    for (int i = 0; i < 5; i++) cycle(1, i[0], 1, 32'h4);
    do_reset(1);
    run(1);

    run(2);
    cycle(1, 0, 1, 32'h400);
    #1;
    check("bad400_fault", fault, 1'b1);
    check("bad400_pc", pc, 32'hc);
    run(5);

    do_reset(1);
    run(2);
    cycle(0, 0, 0, 0);
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_count", fetch_count, 32'h0);
    run(2);

    for (int i = 0; i < 256; i++) mem[i] = 32'h00000093 | (i << 20);
    do_reset(1);
    cycle(1, 0, 1, 32'h3f8);
    run(3);
    #1;
    check("top_fault", fault, 1'b1);
    check("top_pc", pc, 32'h3fc);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 49) == 0) ? 32'h0 : ($urandom | 32'h1);
      do_reset(1);
      for (int c = 0; c < 150; c++) begin
        cycle(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0),
              rand_target());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-cycle RISC-V core, directly upstream of `instruction_memory`. It holds the program counter and drives the memory's `i_addr` from it. It receives `o_inst` back the same cycle and forwards it to decode, gated by a valid flag. It computes the next PC from sequential increment, stall and redirect inputs, stops on end-of-program (all-zero word), and latches a fault on illegal fetch addresses.

## Interface
Parameters:
- `MEM_SIZE`, 1024: instruction memory size in bytes; address width is `ADDR_W = $clog2(MEM_SIZE)`.
- `RESET_PC`, 32'h00000000: PC loaded on reset; must be word-aligned and below `MEM_SIZE`.
- `CNT_W`, 32: width of the retired-fetch counter.
- `HALT_ON_ZERO`, 1: when 1, fetching 32'h00000000 halts the unit.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `i_stall`  in  1  hold the PC this cycle.
- `i_redirect`  in  1  taken branch or jump; load `i_target`.
- `i_target`  in  32  redirect target byte address.
- `i_inst`  in  `INST_WIDTH`  word returned by `instruction_memory.o_inst`.
- `o_addr`  out  `ADDR_W`  to `instruction_memory.i_addr`; equals `pc[ADDR_W-1:0]`.
- `o_pc`  out  32  current PC.
- `o_pc_plus4`  out  32  `pc + 4`, for JAL/JALR link.
- `o_inst`  out  `INST_WIDTH`  instruction to decode; 32'h00000013 (NOP) when not valid.
- `o_valid`  out  1  `o_inst` is a real instruction to execute this cycle.
- `o_halted`  out  1  end-of-program reached.
- `o_fault`  out  1  illegal fetch address requested.
- `o_fetch_count`  out  `CNT_W`  number of valid cycles since reset; saturating.

## Operation
- FSM states: RUN, HALT, FAULT. Reset enters RUN. HALT and FAULT are exited only by reset.
- `o_addr`, `o_pc` and `o_pc_plus4` are combinational from the PC register. `o_halted` is 1 iff the state is HALT. `o_fault` is 1 iff the state is FAULT.
- `zero_inst` = `HALT_ON_ZERO && i_inst == 0`.
- `o_valid` = RUN && !`i_stall` && !`zero_inst`. `o_inst` = `o_valid ? i_inst : 32'h00000013`.
- Next-state and next-PC priority, evaluated in RUN:
  1. `i_stall`: PC holds; `i_redirect` is ignored, and the requester must hold it until unstalled.
  2. `zero_inst`: go to HALT; PC holds at the zero word's address; `i_redirect` is ignored.
  3. `i_redirect`:
     - If `i_target[1:0] != 0` or `i_target >= MEM_SIZE`: go to FAULT, PC holds.
     - Otherwise PC <= `i_target`.
  4. Otherwise:
     - If `pc + 4 >= MEM_SIZE`: go to FAULT, PC holds. There is no wrap-around.
     - Otherwise PC <= `pc + 4`.
- In HALT and FAULT the PC, counter and state hold, and all inputs except `i_rst_n` are ignored.
- `o_fetch_count` increments by 1 on each rising edge where `o_valid` = 1. It saturates at all-ones.
- Width rules:
  - PC arithmetic is 32-bit; the comparisons against `MEM_SIZE` use full 32-bit values.
  - `o_addr` truncates to `ADDR_W` bits, which is lossless because the PC is always below `MEM_SIZE`.

## Timing
- Reset values, with `i_rst_n` = 0 sampled at an edge:
  - state = RUN, PC = `RESET_PC`, `o_fetch_count` = 0, `o_halted` = 0, `o_fault` = 0.
  - Outputs are valid combinationally from the next cycle onward.
- Reset has priority over all other inputs, in every state and mid-operation.
- Fetch latency is zero cycles, because the memory is combinational: `o_inst` reflects `o_pc` in the same cycle.
- Redirect takes effect at the edge where it is sampled; the target instruction appears in the following cycle.
- A halt or fault is visible on `o_halted` / `o_fault` one cycle after the triggering edge condition. In the triggering cycle itself, `o_valid` is already 0 for the zero word. It is still 1 for the instruction that requested the illegal redirect.
- One PC update per cycle at most.

## Test plan
Memory image: 0x0 = 00108113, 0x4 = 00108193, 0x8 = 00310233, 0xC = fe218ae3, 0x10 onward = 0.
- Reset: hold `i_rst_n` = 0 for 2 edges, then release -> `o_pc` = 0, `o_addr` = 0, `o_inst` = 00108113, `o_valid` = 1, `o_fetch_count` = 0, `o_halted` = 0, `o_fault` = 0.
- Sequential to halt: no stall, no redirect -> `o_pc` goes 0, 4, 8, C, 10 on successive cycles. At 0x10, `o_valid` = 0 and `o_inst` = 00000013. The next cycle shows `o_halted` = 1 with `o_pc` held at 0x10, and `o_fetch_count` = 4 from then on.
- Stall: `i_stall` = 1 for 3 cycles at pc 4 -> `o_pc` stays 4, `o_valid` = 0, `o_inst` = 00000013, and the count is frozen. After release, the pc reaches 8 one edge later.
- Redirect: at pc 0xC, `i_redirect` = 1 with `i_target` = 0 -> next `o_pc` = 0 with `o_inst` = 00108113, and the count keeps incrementing.
- Illegal redirects:
  - At pc 0xC, `i_target` = 0x6 -> the next cycle shows `o_fault` = 1, `o_pc` = 0xC, `o_valid` = 0. This holds for 5 cycles, and reset clears it.
  - A separate run with `i_target` = 0x400 produces the same response.
- Reset mid-run: `i_rst_n` = 0 while at pc 8 with count 2 -> after the edge, `o_pc` = 0 and count = 0. Also assert reset from HALT and from FAULT: both must return to RUN.
